// File: rtl/mux_32_8_pkg.sv
// -----------------------------------------------------------------------------
// mux_32_8_pkg
// Shared widths, idle-byte default, FSM state type and byte-select helper
// for the 32<->8 PCI physical-layer byte path (mux_32_8, demux_8_32 and
// future lane width converters).
// -----------------------------------------------------------------------------
package mux_32_8_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 2;

  // Index of the last (least significant) byte of a word.
  localparam logic [CNT_W-1:0]  LAST_IDX          = 2'd3;
  localparam logic [CNT_W-1:0]  FIRST_IDX         = 2'd0;
  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'h00;

  // Serialiser state; the encoding is the "active" flag itself.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } mux_state_e;

  // Byte idx of a word, byte 0 being the most significant (bits 31:24).
  function automatic logic [BYTE_W-1:0] word_byte(
    input logic [WORD_W-1:0] word,
    input logic [CNT_W-1:0]  idx
  );
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mux_32_8_hold.sv
// -----------------------------------------------------------------------------
// mux_32_8_hold
// One-entry word holding buffer with ready handshake. A word is pushed only
// while the entry is empty and popped only while it is full, so push and pop
// never coincide. ready_o depends on registered state only.
//
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   synchronous active-high reset (empties the entry)
//   push_i   in   store data_i (ignored when full)
//   data_i   in   [WORD_W-1:0] word to store
//   pop_i    in   release the stored word (ignored when empty)
//   data_o   out  [WORD_W-1:0] stored word
//   valid_o  out  entry holds a word
//   ready_o  out  entry is empty and can take a word
// -----------------------------------------------------------------------------
module mux_32_8_hold
  import mux_32_8_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  output logic              ready_o
);

  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // Next-state for the single buffer entry.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (push_i && !valid_q) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (pop_i && valid_q) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= {WORD_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ready_o = ~valid_q;

endmodule

// File: rtl/mux_32_8.sv
// -----------------------------------------------------------------------------
// mux_32_8
// Serialises 32-bit words into 8-bit bytes, one byte per clk_4f cycle, most
// significant byte first. The byte stream (data_out/valid_out/first_byte) is
// the input format of demux_8_32. A one-word holding buffer lets the producer
// hand over the next word while the current one is still being shifted out,
// so a producer that keeps up yields a gap-free stream.
//
// Ports:
//   clk_4f      in   byte clock, rising edge
//   reset       in   synchronous active-high reset
//   data_in     in   [31:0] word to serialise
//   valid_in    in   data_in valid this cycle
//   in_ready    out  a word can be accepted this cycle (from registered state)
//   data_out    out  [7:0] serialised byte (IDLE_BYTE when not valid), registered
//   valid_out   out  data_out carries a real byte, registered
//   first_byte  out  data_out is byte 0 (bits 31:24) of a word, registered
// -----------------------------------------------------------------------------
module mux_32_8
  import mux_32_8_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        in_ready,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        first_byte
);

  mux_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              first_q, first_d;

  logic              accept;
  logic              pend_push;
  logic              pend_pop;
  logic [WORD_W-1:0] pend_data;
  logic              pend_v;
  logic              pend_ready;

  // Pending-word buffer; in_ready is simply "buffer empty".
  mux_32_8_hold u_hold (
    .clk_i   (clk_4f),
    .reset_i (reset),
    .push_i  (pend_push),
    .data_i  (data_in),
    .pop_i   (pend_pop),
    .data_o  (pend_data),
    .valid_o (pend_v),
    .ready_o (pend_ready)
  );

  assign in_ready = pend_ready;
  assign accept   = valid_in & pend_ready;

  // Next-state and next-output logic of the IDLE/SEND serialiser.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    data_out_d  = IDLE_BYTE;
    valid_out_d = 1'b0;
    first_d     = 1'b0;
    pend_push   = 1'b0;
    pend_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          word_d  = data_in;
          cnt_d   = FIRST_IDX;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        data_out_d  = word_byte(word_q, cnt_q);
        valid_out_d = 1'b1;
        first_d     = (cnt_q == FIRST_IDX);
        // Wraps 3 -> 0 so the next word always starts at byte 0.
        cnt_d       = cnt_q + 2'd1;

        if (cnt_q != LAST_IDX) begin
          // Mid-word: a new word can only go to the holding buffer.
          pend_push = accept;
        end else if (pend_v) begin
          // Last byte going out: the buffered word follows without a gap.
          word_d   = pend_data;
          pend_pop = 1'b1;
        end else if (accept) begin
          // Buffer empty but producer has a word right now: load directly.
          word_d = data_in;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = FIRST_IDX;
      end
    endcase
  end

  // Serialiser state and registered outputs with synchronous reset.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= FIRST_IDX;
      word_q      <= {WORD_W{1'b0}};
      data_out_q  <= IDLE_BYTE;
      valid_out_q <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      first_q     <= first_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign first_byte = first_q;

endmodule

// File: tb/tb_mux_32_8.sv
// -----------------------------------------------------------------------------
// tb_mux_32_8
// Self-checking bench for mux_32_8. The reference model is a byte queue:
// every accepted word appends its four bytes (MSB first), every clock edge
// emits the head byte if any, and a word is accepted only while at most one
// word's worth of bytes is still queued. Accepted words are also reassembled
// from the output stream and compared in order.
// -----------------------------------------------------------------------------
module tb_mux_32_8;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        in_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        first_byte;

  always #5 clk_4f = ~clk_4f;

  mux_32_8 dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .first_byte (first_byte)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0]  bq_data[$];
  logic        bq_first[$];
  logic [7:0]  exp_data;
  logic        exp_valid;
  logic        exp_first;

  // Loopback reassembly.
  bit          track = 1'b0;
  logic [31:0] sent_words[$];
  logic [31:0] got_words[$];
  logic [31:0] asm_word;
  int          asm_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (bq_data.size() <= 4);
  endfunction

  // One clock cycle: inputs already driven; checks in_ready before the edge
  // and the registered outputs half a cycle after it.
  task automatic cycle(output bit acc);
    if (!reset) check_eq("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    acc = !reset && valid_in && model_ready();
    @(posedge clk_4f);
    if (reset) begin
      bq_data.delete();
      bq_first.delete();
      exp_data  = 8'h00;
      exp_valid = 1'b0;
      exp_first = 1'b0;
      acc       = 1'b0;
    end else begin
      if (bq_data.size() > 0) begin
        exp_data  = bq_data.pop_front();
        exp_first = bq_first.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_first = 1'b0;
      end
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          bq_data.push_back(data_in[31-8*i -: 8]);
          bq_first.push_back(i == 0);
        end
        if (track) sent_words.push_back(data_in);
      end
    end
    @(negedge clk_4f);
    check_eq("data_out",   {24'd0, data_out},   {24'd0, exp_data});
    check_eq("valid_out",  {31'd0, valid_out},  {31'd0, exp_valid});
    check_eq("first_byte", {31'd0, first_byte}, {31'd0, exp_first});
    if (track && valid_out) begin
      if (first_byte) asm_cnt = 0;
      asm_word = {asm_word[23:0], data_out};
      asm_cnt++;
      if (asm_cnt == 4) begin
        got_words.push_back(asm_word);
        asm_cnt = 0;
      end
    end
  endtask

  // Present a word and hold it until the model says it was accepted.
  task automatic send_word(input logic [31:0] w);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    data_in  = w;
    valid_in = 1'b1;
    while (!a && n < 40) begin
      cycle(a);
      n++;
    end
    check_eq("send_accept", {31'd0, a}, 32'd1);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  initial begin
    bit a;
    logic [31:0] stream_words[3];
    stream_words[0] = 32'h11223344;
    stream_words[1] = 32'h55667788;
    stream_words[2] = 32'h99AABBCC;

    // Reset held 3 cycles with a word presented: nothing accepted.
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'hDEADBEEF;
    @(negedge clk_4f);
    for (int i = 0; i < 3; i++) cycle(a);
    reset    = 1'b0;
    valid_in = 1'b0;
    check_eq("ready_after_reset", {31'd0, in_ready}, 32'd1);
    idle(2);

    // Single word, then idle bytes.
    send_word(32'hA1B2C3D4);
    idle(6);

    // Back-to-back stream of three words.
    for (int i = 0; i < 3; i++) send_word(stream_words[i]);
    idle(6);

    // Word offered while the holding buffer is full must be dropped.
    send_word(32'h0F0E0D0C);
    send_word(32'h10203040);
    check_eq("pend_full", {31'd0, in_ready}, 32'd0);
    data_in  = 32'hFFFFFFFF;
    valid_in = 1'b1;
    cycle(a);
    valid_in = 1'b0;
    idle(10);

    // Reset while byte 2 is on the output and a word is pending.
    send_word(32'h0A0B0C0D);
    send_word(32'h01020304);
    idle(2);
    check_eq("mid_byte2", {24'd0, data_out}, 32'h0000000C);
    reset = 1'b1;
    cycle(a);
    reset = 1'b0;
    idle(10);

    // Randomised loopback of 256 words with random producer gaps.
    track = 1'b1;
    sent_words.delete();
    got_words.delete();
    for (int w = 0; w < 256; w++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 5)); g++) begin
          data_in = $urandom;
          cycle(a);
        end
      end
      send_word($urandom);
    end
    idle(10);
    track = 1'b0;
    check_eq("sent_count", sent_words.size(), 32'd256);
    check_eq("loop_count", got_words.size(), 32'd256);
    for (int i = 0; i < 256; i++) begin
      if (i < got_words.size() && i < sent_words.size())
        check_eq("loop_word", got_words[i], sent_words[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
